fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS datapath. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents the fetched instruction plus PC+4 to decode. It consumes the 32-bit jump address from the jump-target join stage (PC+4[31:28] concatenated with instr[25:0]<<2). It also supplies the `pc_plus4` that feeds that stage's upper nibble.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, level, held until ack
- imem_addr  out  32  fetch address, equals `pc` whenever imem_req=1
- imem_ack  in  1  memory accepts request and returns data in the same cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- stall  in  1  decode cannot accept; hold current instruction
- jump  in  1  take jump_addr as next PC
- jump_addr  in  32  jump target from the join stage
- branch_taken  in  1  take branch_target as next PC
- branch_target  in  32  branch target address
- pc  out  32  address of the current/in-flight instruction
- pc_plus4  out  32  pc + 4, combinational from the pc register
- instr  out  32  registered instruction word
- instr_valid  out  1  instr/pc pair is valid for decode

## Operation
- The FSM has three states. Reset value is IDLE.
  - IDLE: imem_req=0. Go to REQ the next cycle.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack=1: latch imem_rdata into instr, go to VALID. Otherwise stay in REQ, holding the request.
  - VALID: instr_valid=1.
    - stall=1: hold everything, stay in VALID.
    - stall=0: load the next PC and go to REQ.
- Next PC when leaving VALID:
  - jump=1 gives jump_addr.
  - Otherwise branch_taken=1 gives branch_target.
  - Otherwise pc_plus4.
- jump has priority over branch_taken when both are 1.
- Target bits [1:0] are forced to 00 on load. PC is always word-aligned.
- jump, branch_taken and the target inputs are sampled only in VALID with stall=0. They are ignored in all other states and cycles.
- imem_ack is ignored outside REQ. A spurious ack does not alter instr.
- pc_plus4 wraps modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=32'h0000_0000. A sequential advance from there loads pc=0.
- instr is updated only on an accepted ack. It keeps its old value in IDLE and after VALID.

## Timing
- Reset (async, any cycle, including mid-fetch) forces:
  - state=IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4
  - instr=0, instr_valid=0, imem_req=0
- An outstanding request is abandoned. No ack is expected or honoured after reset.
- Cycle 0 is the first rising edge with rst_n=1. The unit is in IDLE during cycle 0 and in REQ during cycle 1.
- With zero-wait memory (ack in the first REQ cycle), instr_valid=1 in the cycle after ack.
- Throughput without stalls is one instruction per 2 cycles (REQ, VALID alternating).
- Each wait cycle (req=1, ack=0) adds one cycle. imem_addr stays stable throughout.
- instr_valid drops in the cycle after VALID is left with stall=0. pc shows the new address in that same cycle.
- Registered outputs: pc, instr, instr_valid. imem_req is decoded from state. pc_plus4 is combinational from pc.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0, memory acks immediately with word = address XOR 32'hA5A5_A5A5, stall=0.
  - imem_addr sequence 0, 4, 8, 12.
  - instr_valid high every second cycle.
  - instr matches the data pattern.
- **Wait states and stall:** hold ack low for 3 cycles at pc=8, then stall=1 for 4 cycles in VALID.
  - imem_req held high for 4 cycles with imem_addr=8.
  - instr/pc frozen during the stall.
  - Next request goes to 12.
- **Redirects:**
  - In VALID at pc=4, jump=1, jump_addr=32'h0040_0010 gives next imem_addr=32'h0040_0010.
  - jump=1 and branch_taken=1 with branch_target=32'h100 together: the jump wins.
  - branch_target=32'h0000_0103 alone loads pc=32'h100.
  - Redirect asserted during REQ is ignored.
- **Wrap-around:** RESET_PC=32'hFFFF_FFFC.
  - pc_plus4=0.
  - After one sequential fetch, imem_addr=0.
- **Mid-fetch reset and spurious ack:**
  - Drop rst_n while in REQ with ack low: imem_req falls immediately (async), pc=RESET_PC, instr_valid=0.
  - ack pulsed during IDLE/VALID: instr unchanged.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, fetches one word at a
// time from instruction memory over a level req/ack handshake, and presents
// the fetched instruction together with pc and pc+4 to decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      VALID = 2'b10
   } state_t;

   // Reset PC with the low bits cleared so the PC can never start misaligned.
   localparam logic [31:0] RESET_PC_WORD = {RESET_PC[31:2], 2'b00};

   state_t      state;
   state_t      state_next;
   logic        load_pc;
   logic        load_instr;
   logic [31:0] target;
   logic [31:0] pc_next;

   // Sequential successor of the current PC; wraps naturally modulo 2^32.
   assign pc_plus4  = pc + 32'd4;
   // The address bus mirrors the PC, so it is stable for the whole request.
   assign imem_addr = pc;

   // Next-PC select: jump beats branch, branch beats sequential advance.
   always_comb begin
      if (jump)
         target = jump_addr;
      else if (branch_taken)
         target = branch_target;
      else
         target = pc_plus4;
      pc_next = {target[31:2], 2'b00};
   end

   // Next-state and control decode for the IDLE -> REQ -> VALID loop.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_next = state;
      imem_req   = 1'b0;
      load_pc    = 1'b0;
      load_instr = 1'b0;
      unique case (state)
         IDLE: begin
            state_next = REQ;
         end
         REQ: begin
            imem_req = 1'b1;
            // Ack is only honoured here; anywhere else it is ignored.
            if (imem_ack) begin
               load_instr = 1'b1;
               state_next = VALID;
            end
         end
         VALID: begin
            // Redirect inputs matter only on the cycle decode releases us.
            if (!stall) begin
               load_pc    = 1'b1;
               state_next = REQ;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, PC, instruction and valid registers; reset abandons any fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC_WORD;
         instr       <= 32'h0000_0000;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         instr_valid <= (state_next == VALID);
         if (load_pc)
            pc <= pc_next;
         if (load_instr)
            instr <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, wait states, stall,
// redirects, PC wrap-around, spurious ack and mid-fetch reset.
module tb_fetch_unit;

   localparam logic [31:0] PATTERN = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst_n;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        jump;
   logic [31:0] jump_addr;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic        instr_valid;

   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic [31:0] w_pc;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_instr;
   logic        w_instr_valid;

   // Memory model controls.
   logic        ack_en;
   logic        force_ack;
   logic [31:0] junk;

   int tests_run;
   int tests_failed;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .instr        (instr),
      .instr_valid  (instr_valid)
   );

   // Second instance runs in lockstep to exercise the wrap-around reset PC.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (w_imem_req),
      .imem_addr    (w_imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .pc           (w_pc),
      .pc_plus4     (w_pc_plus4),
      .instr        (w_instr),
      .instr_valid  (w_instr_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Zero-wait combinational memory; junk perturbs data for spurious acks.
   always @* begin
      imem_ack   = force_ack | (ack_en & imem_req);
      imem_rdata = imem_addr ^ PATTERN ^ junk;
   end

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return addr ^ PATTERN;
   endfunction

   task automatic check(input string tag, input logic [31:0] actual,
                        input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      ack_en        = 1'b1;
      force_ack     = 1'b0;
      junk          = 32'h0;
      stall         = 1'b0;
      jump          = 1'b0;
      jump_addr     = 32'h0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;

      tick();
      tick();
      rst_n = 1'b1;

      // Reset state, still in IDLE.
      check("rst_req",       {31'h0, imem_req},    32'h0);
      check("rst_pc",        pc,                   32'h0);
      check("rst_pc_plus4",  pc_plus4,             32'h4);
      check("rst_instr",     instr,                32'h0);
      check("rst_valid",     {31'h0, instr_valid}, 32'h0);
      check("wrap_pc",       w_pc,                 32'hFFFF_FFFC);
      check("wrap_pc_plus4", w_pc_plus4,           32'h0);

      // Sequential fetch of 0 and 4 with zero-wait memory.
      tick();
      check("seq0_req",   {31'h0, imem_req}, 32'h1);
      check("seq0_addr",  imem_addr,         32'h0);
      check("wrap0_addr", w_imem_addr,       32'hFFFF_FFFC);
      tick();
      check("seq0_valid", {31'h0, instr_valid}, 32'h1);
      check("seq0_instr", instr,                word_at(32'h0));
      check("seq0_pc",    pc,                   32'h0);
      check("seq0_noreq", {31'h0, imem_req},    32'h0);
      tick();
      check("seq4_addr",   imem_addr,            32'h4);
      check("seq4_vlow",   {31'h0, instr_valid}, 32'h0);
      check("wrap_seq",    w_imem_addr,          32'h0);
      tick();
      check("seq4_valid", {31'h0, instr_valid}, 32'h1);
      check("seq4_instr", instr,                word_at(32'h4));

      // Fetch at 8 with three wait cycles, then stall in VALID.
      ack_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_req",   {31'h0, imem_req},    32'h1);
         check("wait_addr",  imem_addr,            32'h8);
         check("wait_valid", {31'h0, instr_valid}, 32'h0);
      end
      tick();
      check("wait4_req",  {31'h0, imem_req}, 32'h1);
      check("wait4_addr", imem_addr,         32'h8);
      ack_en = 1'b1;
      tick();
      check("seq8_valid", {31'h0, instr_valid}, 32'h1);
      check("seq8_instr", instr,                word_at(32'h8));
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stall_valid", {31'h0, instr_valid}, 32'h1);
         check("stall_pc",    pc,                   32'h8);
         check("stall_instr", instr,                word_at(32'h8));
         check("stall_req",   {31'h0, imem_req},    32'h0);
      end
      stall = 1'b0;
      tick();
      check("seq12_addr",  imem_addr,            32'hC);
      check("seq12_vlow",  {31'h0, instr_valid}, 32'h0);
      tick();
      check("seq12_instr", instr, word_at(32'hC));

      // Jump and branch together: the jump wins.
      jump          = 1'b1;
      jump_addr     = 32'h0040_0010;
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0100;
      tick();
      check("jump_addr", imem_addr, 32'h0040_0010);
      // Redirect during REQ must be ignored.
      ack_en    = 1'b0;
      jump_addr = 32'hDEAD_0000;
      tick();
      check("req_redirect_ign", imem_addr, 32'h0040_0010);
      jump         = 1'b0;
      branch_taken = 1'b0;
      ack_en       = 1'b1;
      tick();
      check("jump_pc",       pc,       32'h0040_0010);
      check("jump_instr",    instr,    word_at(32'h0040_0010));
      check("jump_pc_plus4", pc_plus4, 32'h0040_0014);

      // Branch alone with a misaligned target.
      branch_taken  = 1'b1;
      branch_target = 32'h0000_0103;
      tick();
      check("branch_addr", imem_addr, 32'h0000_0100);
      branch_taken = 1'b0;
      tick();
      check("branch_pc", pc, 32'h0000_0100);

      // Spurious ack while stalled in VALID leaves instr alone.
      stall     = 1'b1;
      force_ack = 1'b1;
      junk      = 32'h0000_FFFF;
      tick();
      check("spur_valid_instr", instr,                word_at(32'h100));
      check("spur_valid_v",     {31'h0, instr_valid}, 32'h1);
      force_ack = 1'b0;
      junk      = 32'h0;
      stall     = 1'b0;
      ack_en    = 1'b0;
      tick();
      check("pre_rst_req",  {31'h0, imem_req}, 32'h1);
      check("pre_rst_addr", imem_addr,         32'h104);

      // Asynchronous reset in the middle of an outstanding request.
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req",   {31'h0, imem_req},    32'h0);
      check("mid_rst_pc",    pc,                   32'h0);
      check("mid_rst_p4",    pc_plus4,             32'h4);
      check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
      check("mid_rst_instr", instr,                32'h0);
      tick();

      // Spurious ack during IDLE after reset is ignored.
      rst_n     = 1'b1;
      force_ack = 1'b1;
      junk      = 32'hFF00_FF00;
      tick();
      check("spur_idle_instr", instr,             32'h0);
      check("post_rst_req",    {31'h0, imem_req}, 32'h1);
      check("post_rst_addr",   imem_addr,         32'h0);
      force_ack = 1'b0;
      junk      = 32'h0;
      ack_en    = 1'b1;
      tick();
      check("post_rst_instr", instr,                word_at(32'h0));
      check("post_rst_valid", {31'h0, instr_valid}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
